// File: rtl/vernam_pkg.sv
// Shared constants and helpers for the Vernam decipher peripheral and its keystream generator.
// Port offsets, LFSR taps/default seed and status bit positions live here so both link ends agree.
package vernam_pkg;

   localparam logic [7:0]  OFS_DATA     = 8'd0;
   localparam logic [7:0]  OFS_SEED_LO  = 8'd1;
   localparam logic [7:0]  OFS_SEED_HI  = 8'd2;
   localparam logic [7:0]  OFS_STATUS   = 8'd1;

   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   localparam int TAP_A = 15;
   localparam int TAP_B = 13;
   localparam int TAP_C = 12;
   localparam int TAP_D = 10;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_OVF   = 2;

   typedef enum logic [1:0] {
      WR_NONE,
      WR_DATA,
      WR_SEED_LO,
      WR_SEED_HI
   } wr_access_e;

   function automatic logic [15:0] lfsrNext(input logic [15:0] s);
      return {s[14:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction

   // An all-zero Fibonacci LFSR never leaves zero, so such seeds fall back to the default.
   function automatic logic [15:0] seedOrDefault(input logic [15:0] s);
      return (s == 16'h0000) ? LFSR_DEFAULT : s;
   endfunction

endpackage

// File: rtl/vernam_decipher_lfsr.sv
// 16-bit Fibonacci keystream generator shared by the encrypt and decrypt ends of the link.
// A load takes priority over a step; key is the low byte of the current state.
module keystream_lfsr16
   import vernam_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        step,
   output logic [7:0]  key
);

   logic [15:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_val;
      end else if (step) begin
         state_d = lfsrNext(state_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LFSR_DEFAULT;
      end else begin
         state_q <= state_d;
      end
   end

   assign key = state_q[7:0];

endmodule

// File: rtl/vernam_decipher.sv
// kcpsm3 port-mapped Vernam decipher: ciphertext XOR keystream into a small plaintext FIFO.
// Reads are registered from port_id every clock, giving the 1-cycle latency kcpsm3 expects.
module vernam_decipher
   import vernam_pkg::*;
#(
   parameter logic [7:0] PORT_BASE = 8'h10,
   parameter int         DEPTH     = 4
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       data_avail
);

   localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [PW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    seedLo_q, seedLo_d;
   logic [7:0]    inPort_q, inPort_d;
   logic          dataAvail_q;

   wr_access_e    wrAccess;
   logic          empty, full, popReq, doPush, overflowEvent, flush;
   logic [7:0]    key, status;

   always_comb begin
      wrAccess = WR_NONE;
      if (write_strobe) begin
         if (port_id == PORT_BASE + OFS_DATA) begin
            wrAccess = WR_DATA;
         end else if (port_id == PORT_BASE + OFS_SEED_LO) begin
            wrAccess = WR_SEED_LO;
         end else if (port_id == PORT_BASE + OFS_SEED_HI) begin
            wrAccess = WR_SEED_HI;
         end
      end
   end

   assign empty         = (count_q == '0);
   assign full          = (count_q == FULL_COUNT);
   assign popReq        = read_strobe && (port_id == PORT_BASE + OFS_DATA) && !empty;
   assign flush         = (wrAccess == WR_SEED_HI);
   // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
   assign doPush        = (wrAccess == WR_DATA) && (!full || popReq);
   assign overflowEvent = (wrAccess == WR_DATA) && full && !popReq;

   keystream_lfsr16 u_keystream (
      .clk      (clk),
      .reset    (reset),
      .load     (flush),
      .load_val (seedOrDefault({out_port, seedLo_q})),
      .step     (doPush),
      .key      (key)
   );

   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      seedLo_d   = seedLo_q;
      if (wrAccess == WR_SEED_LO) begin
         seedLo_d = out_port;
      end
      if (flush) begin
         wrPtr_d    = '0;
         rdPtr_d    = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
         end
         if (popReq) begin
            rdPtr_d = rdPtr_q + 1'b1;
         end
         if (doPush && !popReq) begin
            count_d = count_q + 1'b1;
         end else if (!doPush && popReq) begin
            count_d = count_q - 1'b1;
         end
         if (overflowEvent) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_comb begin
      status               = 8'h00;
      status[STAT_EMPTY]   = empty;
      status[STAT_FULL]    = full;
      status[STAT_OVF]     = overflow_q;
      inPort_d             = 8'h00;
      if (port_id == PORT_BASE + OFS_DATA) begin
         inPort_d = empty ? 8'h00 : mem[rdPtr_q];
      end else if (port_id == PORT_BASE + OFS_STATUS) begin
         inPort_d = status;
      end
   end

   // Storage needs no reset: count and pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (doPush && !reset) begin
         mem[wrPtr_q] <= out_port ^ key;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         seedLo_q    <= 8'h00;
         inPort_q    <= 8'h00;
         dataAvail_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         seedLo_q    <= seedLo_d;
         inPort_q    <= inPort_d;
         dataAvail_q <= (count_d != '0);
      end
   end

   assign in_port    = inPort_q;
   assign data_avail = dataAvail_q;

endmodule

// File: tb/tb_vernam_decipher.sv
// Scoreboard bench for vernam_decipher: every cycle's expected in_port/data_avail is queued by
// the stimulus side from a queue-based reference model and checked by an independent monitor.
module tb_vernam_decipher;

   localparam logic [7:0] BASE  = 8'h10;
   localparam int         DEPTH = 4;

   logic       clk;
   logic       reset;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   logic       data_avail;

   typedef struct {
      logic [7:0] inPort;
      logic       avail;
      string      tag;
   } exp_t;

   exp_t       expQ[$];
   int         checks = 0;
   int         errors = 0;

   // Reference model state: plaintext queue, sticky overflow, keystream state and low seed byte.
   logic [7:0]  modelFifo[$];
   logic        modelOvf;
   logic [15:0] modelLfsr;
   logic [7:0]  modelSeedLo;

   vernam_decipher #(
      .PORT_BASE (BASE),
      .DEPTH     (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .port_id      (port_id),
      .out_port     (out_port),
      .write_strobe (write_strobe),
      .read_strobe  (read_strobe),
      .in_port      (in_port),
      .data_avail   (data_avail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keystream advance written as plain arithmetic: shift left, append parity of taps 15,13,12,10.
   function automatic logic [15:0] modelStep(input logic [15:0] s);
      int v;
      int fb;
      v  = int'(s);
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      return 16'(((v << 1) | fb) & 32'hFFFF);
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Drives one clock cycle of bus activity, updates the model and queues the expected outputs.
   task automatic applyStimulus(input logic rst, input logic wr, input logic rd,
                                input logic [7:0] port, input logic [7:0] data,
                                input logic useForced, input logic [7:0] forced,
                                input string tag);
      exp_t        e;
      logic        popping;
      logic [15:0] seed;
      reset        = rst;
      write_strobe = wr;
      read_strobe  = rd;
      port_id      = port;
      out_port     = data;

      e.inPort = 8'h00;
      if (!rst) begin
         if (port == BASE) begin
            e.inPort = (modelFifo.size() > 0) ? modelFifo[0] : 8'h00;
         end else if (port == BASE + 8'd1) begin
            e.inPort = {5'b0, modelOvf, modelFifo.size() == DEPTH, modelFifo.size() == 0};
         end
      end
      if (useForced) begin
         e.inPort = forced;
      end

      if (rst) begin
         modelFifo.delete();
         modelOvf    = 1'b0;
         modelLfsr   = 16'hACE1;
         modelSeedLo = 8'h00;
      end else begin
         popping = rd && (port == BASE) && (modelFifo.size() > 0);
         if (wr && port == BASE + 8'd2) begin
            seed = {data, modelSeedLo};
            modelLfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
            modelFifo.delete();
            modelOvf = 1'b0;
         end else begin
            if (popping) begin
               void'(modelFifo.pop_front());
            end
            if (wr && port == BASE) begin
               if (modelFifo.size() < DEPTH) begin
                  modelFifo.push_back(data ^ modelLfsr[7:0]);
                  modelLfsr = modelStep(modelLfsr);
               end else begin
                  modelOvf = 1'b1;
               end
            end
            if (wr && port == BASE + 8'd1) begin
               modelSeedLo = data;
            end
         end
      end
      e.avail = (modelFifo.size() != 0);
      e.tag   = tag;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic wrPort(input logic [7:0] ofs, input logic [7:0] data);
      applyStimulus(1'b0, 1'b1, 1'b0, BASE + ofs, data, 1'b0, 8'h00, "write");
   endtask

   task automatic checkRead(input logic [7:0] ofs, input logic [7:0] value, input string tag);
      applyStimulus(1'b0, 1'b0, 1'b1, BASE + ofs, 8'h00, 1'b1, value, tag);
   endtask

   task automatic modelRead(input logic [7:0] ofs, input string tag);
      applyStimulus(1'b0, 1'b0, 1'b1, BASE + ofs, 8'h00, 1'b0, 8'h00, tag);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, BASE + 8'd1, 8'h00, 1'b0, 8'h00, "reset");
   endtask

   // Monitor: in_port and data_avail are registered, so each queued cycle is checked after its edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            checkOutput({e.tag, " in_port"}, in_port, e.inPort);
            checkOutput({e.tag, " data_avail"}, {7'b0, data_avail}, {7'b0, e.avail});
         end
      end
   end

   initial begin
      reset        = 1'b1;
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      port_id      = 8'h00;
      out_port     = 8'h00;
      modelOvf     = 1'b0;
      modelLfsr    = 16'hACE1;
      modelSeedLo  = 8'h00;
      @(posedge clk);
      #1;

      // Reset state
      doReset();
      doReset();
      checkRead(8'd1, 8'h01, "reset status");
      checkRead(8'd0, 8'h00, "reset empty data");

      // Seed 0x0001: keys 0x01, 0x02
      wrPort(8'd1, 8'h01);
      wrPort(8'd2, 8'h00);
      wrPort(8'd0, 8'h40);
      wrPort(8'd0, 8'h41);
      checkRead(8'd1, 8'h00, "two held status");
      checkRead(8'd0, 8'h41, "seed1 first");
      checkRead(8'd0, 8'h43, "seed1 second");
      checkRead(8'd1, 8'h01, "drained status");

      // Seed 0x8000: keys 0x00 then 0x01
      wrPort(8'd1, 8'h00);
      wrPort(8'd2, 8'h80);
      wrPort(8'd0, 8'h00);
      wrPort(8'd0, 8'h00);
      checkRead(8'd0, 8'h00, "seed8000 first");
      checkRead(8'd0, 8'h01, "seed8000 second");

      // Zero seed falls back to 0xACE1
      wrPort(8'd1, 8'h00);
      wrPort(8'd2, 8'h00);
      wrPort(8'd0, 8'h00);
      checkRead(8'd0, 8'hE1, "zero seed key");

      // Overflow: five pushes into a depth-4 FIFO
      wrPort(8'd2, 8'h00);
      for (int i = 0; i < 5; i++) begin
         wrPort(8'd0, 8'(8'h30 + i));
      end
      checkRead(8'd1, 8'h06, "full overflow status");
      for (int i = 0; i < 4; i++) begin
         modelRead(8'd0, "overflow pop");
      end
      checkRead(8'd1, 8'h05, "drained overflow status");
      wrPort(8'd0, 8'h34);
      modelRead(8'd0, "after overflow push");

      // Seed write flushes; reset mid-stream restores defaults
      wrPort(8'd0, 8'h11);
      wrPort(8'd0, 8'h22);
      wrPort(8'd2, 8'h12);
      checkRead(8'd1, 8'h01, "flush status");
      wrPort(8'd0, 8'h55);
      wrPort(8'd0, 8'h66);
      doReset();
      checkRead(8'd1, 8'h01, "midreset status");
      wrPort(8'd0, 8'h00);
      checkRead(8'd0, 8'hE1, "midreset key");

      // Simultaneous push and pop on a full FIFO
      for (int i = 0; i < 4; i++) begin
         wrPort(8'd0, 8'(8'hA0 + i));
      end
      applyStimulus(1'b0, 1'b1, 1'b1, BASE, 8'h5A, 1'b0, 8'h00, "push pop full");
      modelRead(8'd1, "push pop status");

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         int         sel;
         logic [7:0] p;
         sel = int'($urandom_range(0, 19));
         if (sel < 9)        p = BASE;
         else if (sel < 15)  p = BASE + 8'd1;
         else if (sel == 15) p = BASE + 8'd2;
         else if (sel == 16) p = BASE + 8'd3;
         else                p = 8'($urandom_range(0, 255));
         applyStimulus(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), p, 8'($urandom_range(0, 255)),
                       1'b0, 8'h00, "random");
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "idle");
      repeat (2) @(negedge clk);
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vernam_decipher.md
Name: vernam_decipher

Overview:
- PicoBlaze port-mapped peripheral that is the receive/decrypt end of the Vernam link. Mirrors the encrypting pair (cipher core XORing with a random-key core).
- Accepts ciphertext bytes written by a kcpsm3 OUTPUT instruction and XORs each byte with an on-chip LFSR keystream. Buffers the plaintext in a small FIFO, which the same kcpsm3 drains with INPUT instructions.
- Sits on one kcpsm3 port bus beside the existing RAM and MUX peripherals.

Parameters:
- PORT_BASE, 8'h10, base port_id; block decodes PORT_BASE..PORT_BASE+2.
- DEPTH, 4, plaintext FIFO depth; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- port_id  input  8  kcpsm3 port_id.
- out_port  input  8  kcpsm3 out_port (write data into block).
- write_strobe  input  1  kcpsm3 write_strobe.
- read_strobe  input  1  kcpsm3 read_strobe.
- in_port  output  8  registered read data to kcpsm3 in_port.
- data_avail  output  1  registered; 1 when the FIFO is not empty (usable as interrupt).

Behaviour:
- Reset (synchronous, active-high) sets:
  - lfsr = 16'hACE1, seed_lo = 8'h00
  - FIFO empty (pointers 0, count 0)
  - overflow = 0, in_port = 8'h00, data_avail = 0
- Writes (write_strobe=1, decoded on port_id):
  - PORT_BASE+0: push out_port ^ lfsr[7:0] into the FIFO, then step the LFSR. If the FIFO is full, drop the byte, do not step the LFSR, and set sticky overflow=1.
  - PORT_BASE+1: seed_lo <= out_port.
  - PORT_BASE+2: lfsr <= {out_port, seed_lo}. If that value is 16'h0000, load 16'hACE1 instead (avoids lock-up). The same write empties the FIFO and clears overflow.
  - Any other port_id: ignored.
- LFSR step (Fibonacci, left shift):
  - fb = s[15]^s[13]^s[12]^s[10]
  - s_next = {s[14:0], fb}
  - The key for a byte is lfsr[7:0] before that byte's step.
- Read data path:
  - in_port is registered every clock from port_id, giving 1-cycle latency. This matches kcpsm3 timing: port_id is stable 2 cycles and the strobe is on the 2nd.
  - port_id = PORT_BASE+0: FIFO head, or 8'h00 if empty.
  - port_id = PORT_BASE+1: status {5'b0, overflow, full, empty}.
  - Any other port_id: 8'h00.
- Pop: read_strobe=1 with port_id=PORT_BASE+0 and FIFO not empty advances the read pointer at that edge. A read on an empty FIFO has no effect.
- Simultaneous push and pop (not generated by kcpsm3, but defined):
  - Both are performed and the count is unchanged.
  - A push on a full FIFO in the same cycle as a pop is accepted (no overflow).
- Seed write in the same cycle as a pop: the flush wins.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH.
- full = (count==DEPTH), empty = (count==0). data_avail = !empty, registered.
- Reset mid-operation discards all FIFO contents and restores the default seed.

Decomposition:
- Package vernam_pkg:
  - port offsets OFS_DATA=0, OFS_SEED_LO=1, OFS_SEED_HI=2, OFS_STATUS=1
  - LFSR_DEFAULT=16'hACE1
  - tap positions 15,13,12,10
  - status bit indices EMPTY=0, FULL=1, OVF=2
- Sub-module keystream_lfsr16: ports clk, reset, load, load_val, step, key[7:0]. It is shared with the later hardware encrypt side, so both ends produce identical keystreams.

Test Plan:
- Reset, then read PORT_BASE+1 -> in_port=8'h01 (empty); data_avail=0; read PORT_BASE+0 -> 8'h00.
- Seed 0x0001 (write lo=01, hi=00), then write ciphertext 0x40 and 0x41:
  - keys are 0x01 and 0x02
  - reads return 0x41 then 0x43
  - data_avail drops after the 2nd pop.
- Seed 0x8000, push ciphertext 0x00 twice:
  - keys are 0x00, then 0x01 (fb=1 at s[15])
  - plaintext 0x00, 0x01.
- Seed 0x0000 -> behaves as 0xACE1: push 0x00 -> read 0xE1.
- With DEPTH=4, push 5 bytes:
  - status reads 8'h06 (full, overflow)
  - pop 4 bytes in order; the 5th is dropped
  - a further push uses the key that would have served the 5th byte.
- With the FIFO holding 2 bytes, write a seed -> status 8'h01; assert reset mid-stream -> status 8'h01, next key = 0xE1.
